// File: rtl/lock_pkg.sv
// Shared state encoding, status colours and lockout-length helper for the
// password lockout controller.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_LOCK     = 2'd1,
        ST_DEFAULT  = 2'd2,
        ST_DEF_LOCK = 2'd3
    } lock_state_e;

    localparam logic [2:0] RGB_NORMAL   = 3'b010;
    localparam logic [2:0] RGB_LOCK     = 3'b100;
    localparam logic [2:0] RGB_DEFAULT  = 3'b001;
    localparam logic [2:0] RGB_DEF_LOCK = 3'b101;

    // Product of base length and multiplier, clamped to what the countdown can hold.
    function automatic int sat_prod(input int a, input int b, input int lim);
        int p;
        p = a * b;
        return (p > lim) ? lim : p;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by both lockout states; stops at zero.
module lock_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          tick,
    output logic [CW-1:0] value,
    output logic          zero
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign value = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/pass_lockout_ctrl.sv
// Password entry controller: counts wrong entries, escalates lockouts per round,
// and falls back to a default password after MAX_ROUNDS lockouts.
module pass_lockout_ctrl
    import lock_pkg::*;
#(
    parameter int MAX_TRIES     = 3,
    parameter int MAX_ROUNDS    = 3,
    parameter int LOCK_SECS     = 5,
    parameter int DEF_LOCK_SECS = 9,
    parameter int CW            = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enter,
    input  logic                  pass_ok,
    input  logic                  def_ok,
    input  logic                  tick,
    output logic                  granted,
    output logic                  counting,
    output logic [CW-1:0]         countdown,
    output logic [3:0]            tries_left,
    output logic [MAX_ROUNDS:0]   led_rounds,
    output logic                  mode_def,
    output logic [2:0]            led_rgb
);

    localparam int RW     = $clog2(MAX_ROUNDS + 1);
    localparam int CD_MAX = (1 << CW) - 1;

    lock_state_e   state_q, state_d;
    logic [3:0]    try_cnt_q, try_cnt_d;
    logic [RW-1:0] round_cnt_q, round_cnt_d;
    logic          granted_q, granted_d;
    logic          counting_q, counting_d;
    logic          mode_def_q, mode_def_d;
    logic [2:0]    led_rgb_q, led_rgb_d;

    logic          tmr_load;
    logic [CW-1:0] tmr_load_value;
    logic          tmr_tick;
    logic          tmr_zero;
    logic          expire;
    logic [RW-1:0] round_next;

    assign round_next = round_cnt_q + 1'b1;
    // Timer only advances in the lockout states; expire marks the 1->0 tick.
    assign tmr_tick = tick && ((state_q == ST_LOCK) || (state_q == ST_DEF_LOCK));
    assign expire   = tmr_tick && (countdown == CW'(1));

    always_comb begin
        state_d        = state_q;
        try_cnt_d      = try_cnt_q;
        round_cnt_d    = round_cnt_q;
        granted_d      = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        case (state_q)
            ST_NORMAL: begin
                if (enter) begin
                    if (pass_ok) begin
                        granted_d   = 1'b1;
                        try_cnt_d   = '0;
                        round_cnt_d = '0;
                    end else if (try_cnt_q + 4'd1 == 4'(MAX_TRIES)) begin
                        try_cnt_d      = 4'(MAX_TRIES);
                        round_cnt_d    = round_next;
                        tmr_load       = 1'b1;
                        tmr_load_value = CW'(sat_prod(LOCK_SECS, int'(round_next), CD_MAX));
                        state_d        = ST_LOCK;
                    end else begin
                        try_cnt_d = try_cnt_q + 4'd1;
                    end
                end
            end
            ST_LOCK: begin
                if (expire) begin
                    try_cnt_d = '0;
                    state_d   = (round_cnt_q == RW'(MAX_ROUNDS)) ? ST_DEFAULT : ST_NORMAL;
                end
            end
            ST_DEFAULT: begin
                if (enter) begin
                    if (def_ok) begin
                        granted_d   = 1'b1;
                        try_cnt_d   = '0;
                        round_cnt_d = '0;
                        state_d     = ST_NORMAL;
                    end else begin
                        tmr_load       = 1'b1;
                        tmr_load_value = CW'(sat_prod(DEF_LOCK_SECS, 1, CD_MAX));
                        state_d        = ST_DEF_LOCK;
                    end
                end
            end
            default: begin
                if (expire) begin
                    state_d = ST_DEFAULT;
                end
            end
        endcase

        counting_d = (state_d == ST_LOCK) || (state_d == ST_DEF_LOCK);
        mode_def_d = (state_d == ST_DEFAULT) || (state_d == ST_DEF_LOCK);
        case (state_d)
            ST_NORMAL:  led_rgb_d = RGB_NORMAL;
            ST_LOCK:    led_rgb_d = RGB_LOCK;
            ST_DEFAULT: led_rgb_d = RGB_DEFAULT;
            default:    led_rgb_d = RGB_DEF_LOCK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_NORMAL;
            try_cnt_q   <= '0;
            round_cnt_q <= '0;
            granted_q   <= 1'b0;
            counting_q  <= 1'b0;
            mode_def_q  <= 1'b0;
            led_rgb_q   <= RGB_NORMAL;
        end else begin
            state_q     <= state_d;
            try_cnt_q   <= try_cnt_d;
            round_cnt_q <= round_cnt_d;
            granted_q   <= granted_d;
            counting_q  <= counting_d;
            mode_def_q  <= mode_def_d;
            led_rgb_q   <= led_rgb_d;
        end
    end

    lock_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .tick       (tmr_tick),
        .value      (countdown),
        .zero       (tmr_zero)
    );

    assign granted    = granted_q;
    assign counting   = counting_q;
    assign mode_def   = mode_def_q;
    assign led_rgb    = led_rgb_q;
    assign tries_left = 4'(MAX_TRIES) - try_cnt_q;
    assign led_rounds = {{MAX_ROUNDS{1'b0}}, 1'b1} << round_cnt_q;

    // The zero flag is redundant with countdown here but kept on the timer interface.
    logic unused_zero;
    assign unused_zero = tmr_zero;

endmodule

// File: tb/tb_pass_lockout_ctrl.sv
// Directed bench for pass_lockout_ctrl with default parameters.
module tb_pass_lockout_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enter = 1'b0;
    logic       pass_ok = 1'b0;
    logic       def_ok = 1'b0;
    logic       tick = 1'b0;
    logic       granted;
    logic       counting;
    logic [7:0] countdown;
    logic [3:0] tries_left;
    logic [3:0] led_rounds;
    logic       mode_def;
    logic [2:0] led_rgb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pass_lockout_ctrl #(
        .MAX_TRIES(3), .MAX_ROUNDS(3), .LOCK_SECS(5), .DEF_LOCK_SECS(9), .CW(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enter      (enter),
        .pass_ok    (pass_ok),
        .def_ok     (def_ok),
        .tick       (tick),
        .granted    (granted),
        .counting   (counting),
        .countdown  (countdown),
        .tries_left (tries_left),
        .led_rounds (led_rounds),
        .mode_def   (mode_def),
        .led_rgb    (led_rgb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs from the falling edge; return 1ns after the rising edge.
    task automatic step(input logic e, input logic p, input logic d, input logic t);
        @(negedge clk);
        enter = e; pass_ok = p; def_ok = d; tick = t;
        @(posedge clk);
        #1;
        enter = 1'b0; pass_ok = 1'b0; def_ok = 1'b0; tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wrong3();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_granted"},  32'(granted),    32'd0);
        check({tag, "_counting"}, 32'(counting),   32'd0);
        check({tag, "_countdown"},32'(countdown),  32'd0);
        check({tag, "_tries"},    32'(tries_left), 32'd3);
        check({tag, "_rounds"},   32'(led_rounds), 32'b0001);
        check({tag, "_mode_def"}, 32'(mode_def),   32'd0);
        check({tag, "_rgb"},      32'(led_rgb),    32'b010);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Two wrong entries then the right one
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("w1_tries", 32'(tries_left), 32'd2);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("w2_tries", 32'(tries_left), 32'd1);
        check("w2_granted", 32'(granted), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("ok_granted", 32'(granted), 32'd1);
        check("ok_tries", 32'(tries_left), 32'd3);
        check("ok_rgb", 32'(led_rgb), 32'b010);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ok_granted_drop", 32'(granted), 32'd0);

        // Tick in NORMAL is ignored
        ticks(2);
        check("norm_tick_cd", 32'(countdown), 32'd0);
        check("norm_tick_rgb", 32'(led_rgb), 32'b010);

        // Round 1: 5-tick lockout, with enter+tick at countdown 3
        wrong3();
        check("r1_rgb", 32'(led_rgb), 32'b100);
        check("r1_cd", 32'(countdown), 32'd5);
        check("r1_counting", 32'(counting), 32'd1);
        check("r1_tries", 32'(tries_left), 32'd0);
        check("r1_rounds", 32'(led_rounds), 32'b0010);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("lock_enter_cd", 32'(countdown), 32'd5);
        check("lock_enter_granted", 32'(granted), 32'd0);
        ticks(2);
        check("r1_cd3", 32'(countdown), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("et_cd", 32'(countdown), 32'd2);
        check("et_granted", 32'(granted), 32'd0);
        check("et_tries", 32'(tries_left), 32'd0);
        check("et_rgb", 32'(led_rgb), 32'b100);
        ticks(1);
        check("r1_cd1_rgb", 32'(led_rgb), 32'b100);
        ticks(1);
        check("r1_end_rgb", 32'(led_rgb), 32'b010);
        check("r1_end_tries", 32'(tries_left), 32'd3);
        check("r1_end_rounds", 32'(led_rounds), 32'b0010);
        check("r1_end_counting", 32'(counting), 32'd0);
        check("r1_end_cd", 32'(countdown), 32'd0);

        // Round 2: 10-tick lockout
        wrong3();
        check("r2_cd", 32'(countdown), 32'd10);
        check("r2_rounds", 32'(led_rounds), 32'b0100);
        ticks(9);
        check("r2_cd1", 32'(countdown), 32'd1);
        check("r2_cd1_rgb", 32'(led_rgb), 32'b100);
        ticks(1);
        check("r2_end_rgb", 32'(led_rgb), 32'b010);

        // Round 3: 15-tick lockout then DEFAULT mode
        wrong3();
        check("r3_cd", 32'(countdown), 32'd15);
        check("r3_rounds", 32'(led_rounds), 32'b1000);
        ticks(14);
        check("r3_cd1_mode", 32'(mode_def), 32'd0);
        ticks(1);
        check("def_rgb", 32'(led_rgb), 32'b001);
        check("def_mode", 32'(mode_def), 32'd1);
        check("def_rounds", 32'(led_rounds), 32'b1000);
        check("def_counting", 32'(counting), 32'd0);
        ticks(1);
        check("def_tick_cd", 32'(countdown), 32'd0);

        // Wrong default password (normal one ignored) -> DEF_LOCK
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("dl_rgb", 32'(led_rgb), 32'b101);
        check("dl_cd", 32'(countdown), 32'd9);
        check("dl_granted", 32'(granted), 32'd0);
        check("dl_mode", 32'(mode_def), 32'd1);
        check("dl_counting", 32'(counting), 32'd1);
        ticks(9);
        check("dl_end_rgb", 32'(led_rgb), 32'b001);
        check("dl_end_rounds", 32'(led_rounds), 32'b1000);
        check("dl_end_cd", 32'(countdown), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("dok_granted", 32'(granted), 32'd1);
        check("dok_rgb", 32'(led_rgb), 32'b010);
        check("dok_rounds", 32'(led_rounds), 32'b0001);
        check("dok_mode", 32'(mode_def), 32'd0);
        check("dok_tries", 32'(tries_left), 32'd3);

        // Reset mid-lockout at countdown 7
        wrong3();
        ticks(5);
        wrong3();
        ticks(3);
        check("pre_rst_cd", 32'(countdown), 32'd7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        ticks(3);
        check("post_rst_cd", 32'(countdown), 32'd0);
        check("post_rst_rgb", 32'(led_rgb), 32'b010);
        check("post_rst_rounds", 32'(led_rounds), 32'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
